// File: rtl/tensor_core_matrix_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : tensor_core_matrix_buffer
//  Description : Multi-bank DIM x DIM matrix buffer for a tensor core. Rows
//                stream in one per handshake beat (optionally transposed),
//                complete matrices queue FIFO-style across NUM_BANKS banks,
//                and the oldest complete matrix is exposed whole, with an
//                element poke/peek port on that read bank.
//  Revision    : 1.0 - initial release
// ============================================================================
module tensor_core_matrix_buffer #(
    parameter int DATA_WIDTH = 8,
    parameter int DIM        = 4,
    parameter int NUM_BANKS  = 2
) (
    input  logic                               clock_in,
    input  logic                               reset_in,
    input  logic                               load_valid_in,
    output logic                               load_ready_out,
    input  logic [DIM*DATA_WIDTH-1:0]          load_row_data_in,
    input  logic                               load_transpose_in,
    output logic                               matrix_valid_out,
    output logic [DIM*DIM*DATA_WIDTH-1:0]      matrix_data_out,
    input  logic                               matrix_consume_in,
    input  logic                               poke_enable_in,
    input  logic [$clog2(DIM*DIM)-1:0]         poke_address_in,
    input  logic [DATA_WIDTH-1:0]              poke_data_in,
    input  logic [$clog2(DIM*DIM)-1:0]         peek_address_in,
    output logic [DATA_WIDTH-1:0]              peek_data_out,
    output logic [$clog2(NUM_BANKS+1)-1:0]     occupancy_out,
    input  logic                               flush_in
);

    localparam int ROW_W = $clog2(DIM);
    localparam int PTR_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
    localparam int CNT_W = $clog2(NUM_BANKS + 1);
    localparam int MAT_W = DIM * DIM * DATA_WIDTH;

    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(DIM - 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(NUM_BANKS - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(NUM_BANKS);

    logic [MAT_W-1:0]  bank_q [NUM_BANKS];
    logic [MAT_W-1:0]  bank_d [NUM_BANKS];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [ROW_W-1:0]  row_cnt_q, row_cnt_d;
    logic              tp_q, tp_d;

    logic              accept;
    logic              consume;
    logic              last_row;
    logic              complete;
    logic              poke_ok;
    logic              tp_eff;
    logic [MAT_W-1:0]  read_bank;

    assign load_ready_out   = (count_q < FULL_CNT);
    assign matrix_valid_out = (count_q != '0);
    assign occupancy_out    = count_q;

    assign accept   = load_valid_in & load_ready_out;
    assign consume  = matrix_consume_in & matrix_valid_out;
    assign last_row = (row_cnt_q == LAST_ROW);
    assign complete = accept & last_row;
    assign poke_ok  = poke_enable_in & (count_q != '0);
    // The first beat of a matrix already uses the transpose flag it latches.
    assign tp_eff   = (row_cnt_q == '0) ? load_transpose_in : tp_q;

    assign read_bank       = bank_q[rd_ptr_q];
    assign matrix_data_out = read_bank;
    assign peek_data_out   = read_bank[int'(peek_address_in)*DATA_WIDTH +: DATA_WIDTH];

    // Pointer, row counter, transpose latch and occupancy next-state.
    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        row_cnt_d = row_cnt_q;
        tp_d      = tp_q;
        if (flush_in) begin
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            count_d   = '0;
            row_cnt_d = '0;
            tp_d      = 1'b0;
        end else begin
            if (accept) begin
                tp_d = tp_eff;
                if (last_row) begin
                    row_cnt_d = '0;
                    wr_ptr_d  = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PTR_W'(1);
                end else begin
                    row_cnt_d = row_cnt_q + ROW_W'(1);
                end
            end
            if (consume) begin
                rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PTR_W'(1);
            end
            case ({complete, consume})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Bank contents next-state: row load into the write bank, poke into the
    // read bank. They never target the same bank while both are enabled.
    always_comb begin
        for (int b = 0; b < NUM_BANKS; b++) begin
            bank_d[b] = flush_in ? '0 : bank_q[b];
        end
        if (!flush_in) begin
            if (accept) begin
                for (int c = 0; c < DIM; c++) begin
                    if (tp_eff) begin
                        bank_d[wr_ptr_q][(c*DIM + int'(row_cnt_q))*DATA_WIDTH +: DATA_WIDTH] =
                            load_row_data_in[c*DATA_WIDTH +: DATA_WIDTH];
                    end else begin
                        bank_d[wr_ptr_q][(int'(row_cnt_q)*DIM + c)*DATA_WIDTH +: DATA_WIDTH] =
                            load_row_data_in[c*DATA_WIDTH +: DATA_WIDTH];
                    end
                end
            end
            if (poke_ok) begin
                bank_d[rd_ptr_q][int'(poke_address_in)*DATA_WIDTH +: DATA_WIDTH] = poke_data_in;
            end
        end
    end

    // Control state register with asynchronous active-low clear.
    always_ff @(posedge clock_in or negedge reset_in) begin
        if (!reset_in) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            row_cnt_q <= '0;
            tp_q      <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            row_cnt_q <= row_cnt_d;
            tp_q      <= tp_d;
        end
    end

    // Bank storage register; reset zeroes every element.
    always_ff @(posedge clock_in or negedge reset_in) begin
        if (!reset_in) begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                bank_q[b] <= '0;
            end
        end else begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                bank_q[b] <= bank_d[b];
            end
        end
    end

endmodule
`default_nettype wire
